// File: rtl/threefish1024_sequencer.sv
// Iterative Threefish-1024 controller: one even and one odd 4-round group are
// time-shared across 20 passes, with on-the-fly subkey generation and UBI feed-forward.
module threefish1024_sequencer #(
  parameter bit UBI_XOR = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [1023:0] in_key,
  input  logic [127:0]  in_tweak,
  input  logic [1023:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [1023:0] out_data,
  output logic          busy
);

  localparam logic [63:0] C240 = 64'h1BD11BDAA9FC1A22;

  localparam int ROT [8][8] = '{
    '{24, 13,  8, 47,  8, 17, 22, 37},
    '{38, 19, 10, 55, 49, 18, 23, 52},
    '{33,  4, 51, 13, 34, 41, 59, 17},
    '{ 5, 20, 48, 41, 47, 28, 16, 25},
    '{41,  9, 37, 31, 12, 47, 44, 30},
    '{16, 34, 56, 51,  4, 53, 42, 41},
    '{31, 44, 47, 46, 19, 42, 44, 25},
    '{ 9, 48, 35, 52, 23, 31, 37, 20}
  };

  localparam int PERM [16] = '{0, 9, 2, 13, 6, 11, 4, 15, 10, 7, 12, 3, 14, 5, 8, 1};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic [63:0] rotl64(input logic [63:0] x, input int r);
    rotl64 = (x << r) | (x >> (64 - r));
  endfunction

  // One Threefish round: eight MIX operations followed by the word permutation.
  function automatic logic [1023:0] tf_round(input logic [1023:0] x, input int d);
    logic [63:0] f [16];
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] sum;
    for (int j = 0; j < 8; j++) begin
      a          = x[128*j +: 64];
      b          = x[128*j+64 +: 64];
      sum        = a + b;
      f[2*j]     = sum;
      f[2*j+1]   = rotl64(b, ROT[d][j]) ^ sum;
    end
    for (int i = 0; i < 16; i++) begin
      tf_round[64*i +: 64] = f[PERM[i]];
    end
  endfunction

  state_t               state_q, state_d;
  logic [16:0][63:0]    k_q, k_d;
  logic [2:0][63:0]     t_q, t_d;
  logic [1023:0]        s_q, s_d;
  logic [1023:0]        p_q, p_d;
  logic [4:0]           sk_q, sk_d;
  logic [4:0]           pass_q, pass_d;
  logic [1:0]           w_q, w_d;
  logic [1023:0]        out_data_q, out_data_d;
  logic                 out_valid_q, out_valid_d;
  logic [1023:0]        mid_even_q, mid_odd_q;

  logic [1023:0]        subkey;
  logic [1023:0]        group_in;
  logic [1023:0]        even_out;
  logic [1023:0]        odd_out;
  logic [63:0]          key_parity;

  always_comb begin
    key_parity = C240;
    for (int i = 0; i < 16; i++) begin
      key_parity = key_parity ^ in_key[64*i +: 64];
    end
  end

  // K and T rotate on every injection, so the subkey always reads fixed slots.
  always_comb begin
    subkey = '0;
    for (int i = 0; i < 13; i++) begin
      subkey[64*i +: 64] = k_q[i];
    end
    subkey[64*13 +: 64] = k_q[13] + t_q[0];
    subkey[64*14 +: 64] = k_q[14] + t_q[1];
    subkey[64*15 +: 64] = k_q[15] + {59'd0, sk_q};
  end

  always_comb begin
    group_in = '0;
    for (int i = 0; i < 16; i++) begin
      group_in[64*i +: 64] = s_q[64*i +: 64] + subkey[64*i +: 64];
    end
  end

  // Each group is split after two rounds; the held input makes three edges enough.
  assign even_out = tf_round(tf_round(mid_even_q, 2), 3);
  assign odd_out  = tf_round(tf_round(mid_odd_q, 6), 7);

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    t_d         = t_q;
    s_d         = s_q;
    p_d         = p_q;
    sk_d        = sk_q;
    pass_d      = pass_q;
    w_d         = w_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          k_d[15:0] = in_key;
          k_d[16]   = key_parity;
          t_d       = {in_tweak[63:0] ^ in_tweak[127:64], in_tweak[127:64], in_tweak[63:0]};
          s_d       = in_data;
          p_d       = in_data;
          sk_d      = '0;
          pass_d    = '0;
          w_d       = '0;
          state_d   = RUN;
        end
      end
      RUN: begin
        if (pass_q == 5'd20) begin
          out_data_d  = group_in ^ (UBI_XOR ? p_q : '0);
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else if (w_q == 2'd2) begin
          s_d    = pass_q[0] ? odd_out : even_out;
          sk_d   = sk_q + 5'd1;
          pass_d = pass_q + 5'd1;
          w_d    = '0;
          k_d    = {k_q[0], k_q[16:1]};
          t_d    = {t_q[0], t_q[2:1]};
        end else begin
          w_d = w_q + 2'd1;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      k_q         <= '0;
      t_q         <= '0;
      s_q         <= '0;
      p_q         <= '0;
      sk_q        <= '0;
      pass_q      <= '0;
      w_q         <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      mid_even_q  <= '0;
      mid_odd_q   <= '0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      t_q         <= t_d;
      s_q         <= s_d;
      p_q         <= p_d;
      sk_q        <= sk_d;
      pass_q      <= pass_d;
      w_q         <= w_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      mid_even_q  <= tf_round(tf_round(group_in, 0), 1);
      mid_odd_q   <= tf_round(tf_round(group_in, 4), 5);
    end
  end

  // Handshakes: a transfer happens at a rising edge where valid and ready are both high.
  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule
